// File: rtl/sfif_pkg.sv
// Shared definitions for the SFIF Wishbone sample-reader slice.
package sfif_pkg;

  localparam int unsigned WB_DATA_W     = 16;
  localparam logic [17:0] DEF_BASE_ADDR = 18'h02000;
  localparam logic [1:0]  WB_SEL        = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_GAP,
    S_PUSH,
    S_FIN
  } state_t;

endpackage

// File: rtl/wbm_sample_reader_if.sv
// Wishbone master bus plus the 32-bit sample stream, bundled for the reader.
interface wbm_sample_reader_if
  import sfif_pkg::*;
#(
  parameter int unsigned ADDR_W = 18
) ();

  logic [ADDR_W-1:0]      wbm_adr_o;
  logic [WB_DATA_W-1:0]   wbm_dat_o;
  logic                   wbm_we_o;
  logic [1:0]             wbm_sel_o;
  logic                   wbm_cyc_o;
  logic                   wbm_stb_o;
  logic [WB_DATA_W-1:0]   wbm_dat_i;
  logic                   wbm_ack_i;
  logic                   wbm_err_i;

  logic [2*WB_DATA_W-1:0] m_data_o;
  logic                   m_valid_o;
  logic                   m_last_o;
  logic                   m_ready_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output m_data_o, m_valid_o, m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  m_data_o, m_valid_o, m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/wbm_sample_reader.sv
// Hardware-sequenced Wishbone block read of 16-bit samples, packed in pairs
// (low half first) onto a 32-bit valid/ready stream.
module wbm_sample_reader
  import sfif_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       ADDR_STEP = 2,
  parameter int unsigned       LEN_W     = 12,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [ADDR_W-1:0]    offset_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  wbm_sample_reader_if.master  bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_idx;
  logic [ADDR_W-1:0]      r_addr;
  logic [2*WB_DATA_W-1:0] r_word;
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_err;

  logic                   w_fail;
  logic                   w_ack;
  logic [LEN_W-1:0]       w_idx_nx;
  logic                   w_word_done;
  logic                   w_last;

  // err dominates ack; a timeout fires on the TIMEOUT-th unterminated strobe cycle
  always_comb begin
    w_fail      = bus.wbm_err_i || (!bus.wbm_ack_i && (r_tmo == TMO_W'(TIMEOUT - 1)));
    w_ack       = bus.wbm_ack_i && !bus.wbm_err_i;
    w_idx_nx    = r_idx + LEN_W'(1);
    w_word_done = r_idx[0] || (w_idx_nx == r_len);
    w_last      = (r_idx == r_len);
  end

  // State register; async reset aborts any block without a done pulse
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and bus/stream outputs
  always_comb begin
    w_next        = r_state;
    bus.wbm_cyc_o = 1'b0;
    bus.wbm_stb_o = 1'b0;
    bus.m_valid_o = 1'b0;
    bus.m_last_o  = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next = (len_i == '0) ? S_FIN : S_READ;
      end
      S_READ: begin
        bus.wbm_cyc_o = 1'b1;
        bus.wbm_stb_o = 1'b1;
        busy_o        = 1'b1;
        if (w_fail)     w_next = S_FIN;
        else if (w_ack) w_next = w_word_done ? S_PUSH : S_GAP;
      end
      S_GAP: begin
        busy_o = 1'b1;
        w_next = S_READ;
      end
      S_PUSH: begin
        busy_o        = 1'b1;
        bus.m_valid_o = 1'b1;
        bus.m_last_o  = w_last;
        if (bus.m_ready_i) w_next = w_last ? S_FIN : S_READ;
      end
      S_FIN: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Block parameters, address/index counters, pack register, timeout and error flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_addr <= '0;
      r_word <= '0;
      r_tmo  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_len  <= len_i;
            r_idx  <= '0;
            r_addr <= BASE_ADDR + offset_i;
            r_word <= '0;
            r_tmo  <= '0;
            r_err  <= 1'b0;
          end
        end
        S_READ: begin
          if (w_fail) begin
            r_err <= 1'b1;
          end else if (w_ack) begin
            // an even sample starts a fresh word, so an odd block ends with a zero high half
            if (r_idx[0]) r_word[2*WB_DATA_W-1:WB_DATA_W] <= bus.wbm_dat_i;
            else          r_word <= {{WB_DATA_W{1'b0}}, bus.wbm_dat_i};
            r_idx  <= w_idx_nx;
            r_addr <= r_addr + ADDR_W'(ADDR_STEP);
            r_tmo  <= '0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign err_o         = r_err;
  assign bus.wbm_adr_o = r_addr;
  assign bus.wbm_dat_o = '0;
  assign bus.wbm_we_o  = 1'b0;
  assign bus.wbm_sel_o = WB_SEL;
  assign bus.m_data_o  = r_word;

endmodule

// File: tb/tb_wbm_sample_reader.sv
// Scoreboard bench for wbm_sample_reader: random blocks plus directed corner cases.
module tb_wbm_sample_reader;

  localparam logic [17:0] BASE = 18'h02000;
  localparam int          TMO  = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] len = '0;
  logic [17:0] off = '0;
  logic        busy, done, err;

  wbm_sample_reader_if #(.ADDR_W(18)) bus ();

  wbm_sample_reader #(
    .ADDR_W(18), .BASE_ADDR(BASE), .ADDR_STEP(2), .LEN_W(12), .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .len_i(len),
    .offset_i(off), .busy_o(busy), .done_o(done), .err_o(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  typedef struct { logic [31:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input longint act, input longint expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // ---------------- slave model ----------------
  int          s_mode   = 0;   // 0 normal, 1 never terminates, 2 err on read s_err_at
  int          s_err_at = 0;
  bit          s_rand   = 1'b0;
  logic [15:0] s_xor    = '0;
  int          s_rd;
  int          s_wait;

  initial begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;
    bus.wbm_dat_i = '0;
  end

  always @(posedge clk) begin
    bus.wbm_ack_i <= 1'b0;
    bus.wbm_err_i <= 1'b0;
    if (!busy) begin
      s_rd   <= 0;
      s_wait <= 0;
    end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i && !bus.wbm_err_i) begin
      if (s_wait != 0) s_wait <= s_wait - 1;
      else if (s_mode != 1) begin
        if (s_mode == 2 && s_rd == s_err_at) bus.wbm_err_i <= 1'b1;
        else begin
          bus.wbm_ack_i <= 1'b1;
          bus.wbm_dat_i <= bus.wbm_adr_o[15:0] ^ s_xor;
        end
        s_rd   <= s_rd + 1;
        s_wait <= s_rand ? int'($urandom_range(0, 2)) : 0;
      end
    end
  end

  // ---------------- sink ready driver ----------------
  int rdy_mode = 0;   // 0 always ready, 1 random, 2 held low
  initial begin
    bus.m_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.m_ready_i = 1'b1;
        1:       bus.m_ready_i = 1'($urandom_range(0, 1));
        default: bus.m_ready_i = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else if (bus.m_valid_o) begin
        chk("no_bus_in_push", bus.wbm_cyc_o, 0);
        if (prev_stall) begin
          chk("stall_data_hold", bus.m_data_o, prev_data);
          chk("stall_last_hold", bus.m_last_o, prev_last);
        end
        if (bus.m_ready_i) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %08h, expected no word", bus.m_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", bus.m_data_o, e.data);
            chk("word_last", bus.m_last_o, e.last);
          end
        end
        prev_stall = !bus.m_ready_i;
        prev_data  = bus.m_data_o;
        prev_last  = bus.m_last_o;
      end else prev_stall = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] samp(input logic [17:0] o, input int n, input logic [15:0] x);
    logic [17:0] a;
    a = BASE + o + 18'(2 * n);
    return a[15:0] ^ x;
  endfunction

  task automatic run_block(input int l, input logic [17:0] o, input int mode, input int eat,
                           input int rdy, input bit stall, input bit chk_lat);
    int ep, cyc_n, first_stb, first_val, hs_last, done_at, stb_cnt, stall_left, hi;
    logic [17:0] first_adr, exp_adr;
    logic busy1, err1, err_done;
    exp_t w;
    ep = (mode == 0) ? l : ((mode == 1) ? 0 : eat);
    s_mode = mode; s_err_at = eat; s_xor = 16'($urandom);
    for (int k = 0; 2 * k < l; k++) begin
      hi = (2 * k + 1 < l) ? 2 * k + 1 : l - 1;
      if (hi < ep) begin
        w.data[15:0]  = samp(o, 2 * k, s_xor);
        w.data[31:16] = (2 * k + 1 < l) ? samp(o, 2 * k + 1, s_xor) : 16'h0;
        w.last        = (2 * k + 2 >= l);
        exp_q.push_back(w);
      end
    end
    rdy_mode = stall ? 2 : rdy;
    stall_left = stall ? 10 : 0;
    @(negedge clk);
    start = 1'b1; len = 12'(l); off = o;
    cyc_n = 0; first_stb = -1; first_val = -1; hs_last = -1; done_at = -1; stb_cnt = 0;
    busy1 = 1'b0; err1 = 1'b1; err_done = 1'b0; first_adr = '0;
    while (done_at < 0 && cyc_n < 3000) begin
      @(negedge clk);
      cyc_n++;
      if (cyc_n == 1) begin
        start = 1'b0; busy1 = busy; err1 = err;
        len = 12'($urandom); off = 18'($urandom);
      end
      if (bus.wbm_stb_o) begin
        stb_cnt++;
        if (first_stb < 0) begin first_stb = cyc_n; first_adr = bus.wbm_adr_o; end
      end
      if (bus.m_valid_o && first_val < 0) first_val = cyc_n;
      if (bus.m_valid_o && bus.m_ready_i && bus.m_last_o) hs_last = cyc_n;
      if (stall_left > 0 && bus.m_valid_o) begin
        stall_left--;
        if (stall_left == 0) rdy_mode = rdy;
      end
      if (done) begin done_at = cyc_n; err_done = err; end
    end
    if (done_at < 0) begin
      errors++;
      $display("FAIL done_timeout: got no done_o in %0d cycles, expected a done_o pulse", cyc_n);
    end
    chk("err_cleared_by_start", err1, 0);
    chk("err_at_done", err_done, (mode != 0) && (l != 0));
    if (l == 0) begin
      chk("len0_done_latency", done_at, 1);
      chk("len0_no_cycle", stb_cnt, 0);
    end else begin
      exp_adr = BASE + o;
      chk("busy_after_start", busy1, 1);
      chk("first_stb_latency", first_stb, 1);
      chk("first_adr", first_adr, exp_adr);
      if (mode == 1) begin
        chk("timeout_stb_cycles", stb_cnt, TMO);
        chk("timeout_done_at", done_at, first_stb + TMO);
      end
      if (mode == 0) chk("done_after_last_hs", done_at, hs_last + 1);
      if (chk_lat) chk("pair_valid_latency", first_val, first_stb + 5);
    end
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("busy_low_after", busy, 0);
    chk("all_words_seen", exp_q.size(), 0);
    exp_q.delete();
    rdy_mode = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int l, mode;
    #2;
    chk("rst_cyc", bus.wbm_cyc_o, 0);
    chk("rst_stb", bus.wbm_stb_o, 0);
    chk("rst_valid", bus.m_valid_o, 0);
    chk("rst_last", bus.m_last_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_adr", bus.wbm_adr_o, 0);
    chk("rst_data", bus.m_data_o, 0);
    chk("rst_sel", bus.wbm_sel_o, 2'b11);
    chk("rst_we", bus.wbm_we_o, 0);
    chk("rst_dat_o", bus.wbm_dat_o, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // directed: len 4 from offset 0, immediate acks, sink ready
    run_block(4, 18'h0, 0, 0, 0, 1'b0, 1'b1);
    // odd length with a 10-cycle stall on the first word
    run_block(3, 18'h0, 0, 0, 0, 1'b1, 1'b0);
    // zero length
    run_block(0, 18'h40, 0, 0, 0, 1'b0, 1'b0);
    // slave never terminates, then a clean block clears err_o
    run_block(2, 18'h10, 1, 0, 0, 1'b0, 1'b0);
    run_block(2, 18'h10, 0, 0, 0, 1'b0, 1'b0);
    // bus error on the second read
    run_block(4, 18'h0, 2, 1, 0, 1'b0, 1'b0);
    // wrap of the start address below BASE
    run_block(4, 18'h3FFFE, 0, 0, 0, 1'b0, 1'b1);

    // asynchronous reset in the middle of a read
    s_mode = 1;
    @(negedge clk);
    start = 1'b1; len = 12'd8; off = 18'h0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cyc", bus.wbm_cyc_o, 0);
    chk("arst_stb", bus.wbm_stb_o, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", bus.m_valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
    end
    rst = 1'b0;
    run_block(5, 18'h100, 0, 0, 0, 1'b0, 1'b0);

    // randomized blocks
    s_rand = 1'b1;
    for (int b = 0; b < 25; b++) begin
      l = int'($urandom_range(0, 20));
      mode = ($urandom_range(0, 7) == 0 && l != 0) ? 2 : 0;
      run_block(l, 18'($urandom), mode, (l != 0) ? int'($urandom_range(0, l - 1)) : 0,
                1, 1'($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation time limit, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule
